// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared states, character constants and code helpers for the terminal core
package term_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } term_state_t;

    localparam logic [5:0] BLANK_CODE = 6'h00;
    localparam logic [6:0] ASCII_CR   = 7'h0D;
    localparam logic [6:0] ASCII_BS   = 7'h08;

    // 6-bit screen code drops ASCII bit 5; the Apple-1 glyph set is upper case only
    function automatic logic [5:0] to_code(input logic [7:1] rd);
        return {rd[7], rd[5:1]};
    endfunction

    function automatic logic is_ctrl(input logic [7:1] rd);
        return ~rd[7] & ~rd[6];
    endfunction

endpackage

// File: rtl/term_ram.sv
// rtl/term_ram.sv - simple dual-port screen RAM, one write port and a registered read-first read port
module term_ram #(
    parameter int DEPTH  = 960,
    parameter int WIDTH  = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Same-edge collision returns the pre-write contents
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/term_screen_ctrl.sv
// rtl/term_screen_ctrl.sv - character terminal screen buffer controller; TERM_BACKSPACE_EN enables BS handling
module term_screen_ctrl
    import term_pkg::*;
#(
    parameter int COLS  = 40,
    parameter int ROWS  = 24,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             mr,
    input  logic [7:1]       rd,
    input  logic             da,
    output logic             rdy,
    input  logic             clr_btn,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [5:0]       rd_char,
    output logic             rd_curs,
    output logic [ROW_W-1:0] curs_row,
    output logic [COL_W-1:0] curs_col,
    output logic [ROW_W-1:0] top_row
);

    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ROW_W:0]    ROWS_N     = (ROW_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] DEPTH_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);

    term_state_t       r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [COL_W-1:0]  r_scr_col;
    logic [ROW_W-1:0]  r_curs_row;
    logic [COL_W-1:0]  r_curs_col;
    logic [ROW_W-1:0]  r_top_row;
    logic              r_rd_curs;

    logic              w_accept;
    logic              w_ctrl;
    logic              w_newline;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [5:0]        w_wdata;
    logic [ADDR_W-1:0] w_raddr;
`ifdef TERM_BACKSPACE_EN
    logic              w_bs;
`endif

    // Logical row is rotated by top_row so a scroll never moves stored data
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] lrow,
                                                    input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= ROWS_N) begin
            sum = sum - ROWS_N;
        end
        return ADDR_W'(sum) * COLS_A + ADDR_W'(col);
    endfunction

    assign rdy       = (r_state == IDLE);
    assign w_accept  = rdy & da & ~mr & ~clr_btn;
    assign w_ctrl    = is_ctrl(rd);
    assign w_newline = w_accept & (w_ctrl ? (rd == ASCII_CR) : (r_curs_col == COL_LAST));
    assign w_raddr   = cell_addr(rd_row, rd_col, r_top_row);
`ifdef TERM_BACKSPACE_EN
    assign w_bs      = w_accept & (rd == ASCII_BS) & (r_curs_col != '0);
`endif

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = BLANK_CODE;
        if (!mr && !clr_btn) begin
            case (r_state)
                CLEAR: begin
                    w_we = 1'b1;
                end
                SCROLL: begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(ROW_LAST, r_scr_col, r_top_row);
                end
                IDLE: begin
                    if (w_accept && !w_ctrl) begin
                        w_we    = 1'b1;
                        w_waddr = cell_addr(r_curs_row, r_curs_col, r_top_row);
                        w_wdata = to_code(rd);
                    end
`ifdef TERM_BACKSPACE_EN
                    else if (w_bs) begin
                        w_we    = 1'b1;
                        w_waddr = cell_addr(r_curs_row, r_curs_col - COL_W'(1), r_top_row);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mr || clr_btn) begin
            r_state    <= CLEAR;
            r_clr_ptr  <= '0;
            r_scr_col  <= '0;
            r_curs_row <= '0;
            r_curs_col <= '0;
            r_top_row  <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == DEPTH_LAST) begin
                        r_state <= IDLE;
                    end
                end
                SCROLL: begin
                    r_scr_col <= r_scr_col + COL_W'(1);
                    if (r_scr_col == COL_LAST) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_newline) begin
                        r_curs_col <= '0;
                        if (r_curs_row != ROW_LAST) begin
                            r_curs_row <= r_curs_row + ROW_W'(1);
                        end else begin
                            r_top_row <= (r_top_row == ROW_LAST) ? '0 : r_top_row + ROW_W'(1);
                            r_scr_col <= '0;
                            r_state   <= SCROLL;
                        end
                    end else if (w_accept && !w_ctrl) begin
                        r_curs_col <= r_curs_col + COL_W'(1);
                    end
`ifdef TERM_BACKSPACE_EN
                    else if (w_bs) begin
                        r_curs_col <= r_curs_col - COL_W'(1);
                    end
`endif
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mr) begin
            r_rd_curs <= 1'b0;
        end else begin
            r_rd_curs <= (r_state == IDLE) && (rd_row == r_curs_row) && (rd_col == r_curs_col);
        end
    end

    term_ram #(
        .DEPTH (DEPTH),
        .WIDTH (6)
    ) u_ram (
        .clk     (clk),
        .i_rst   (mr),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (rd_char)
    );

    assign rd_curs  = r_rd_curs;
    assign curs_row = r_curs_row;
    assign curs_col = r_curs_col;
    assign top_row  = r_top_row;

endmodule

// File: tb/tb_term_screen_ctrl.sv
// tb/tb_term_screen_ctrl.sv - directed self-checking bench for term_screen_ctrl
module tb_term_screen_ctrl;

    localparam int COLS  = 40;
    localparam int ROWS  = 24;
    localparam int COL_W = 6;
    localparam int ROW_W = 5;

    logic             clk = 1'b0;
    logic             mr;
    logic [7:1]       rd;
    logic             da;
    logic             rdy;
    logic             clr_btn;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [5:0]       rd_char;
    logic             rd_curs;
    logic [ROW_W-1:0] curs_row;
    logic [COL_W-1:0] curs_col;
    logic [ROW_W-1:0] top_row;

    int checks = 0;
    int errors = 0;
    logic [5:0] rdata;
    logic       rcurs;

    term_screen_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk      (clk),
        .mr       (mr),
        .rd       (rd),
        .da       (da),
        .rdy      (rdy),
        .clr_btn  (clr_btn),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_char  (rd_char),
        .rd_curs  (rd_curs),
        .curs_row (curs_row),
        .curs_col (curs_col),
        .top_row  (top_row)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] code_of(input logic [6:0] a);
        return {a[6], a[4:0]};
    endfunction

    task automatic read_cell(input int r, input int c);
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        @(negedge clk);
        rdata = rd_char;
        rcurs = rd_curs;
    endtask

    task automatic send_char(input logic [6:0] a);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rdy=%b required 1", rdy);
        end
        rd = a;
        da = 1'b1;
        @(negedge clk);
        da = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (rdy !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        int bad;
        mr = 1'b1; da = 1'b0; clr_btn = 1'b0; rd = '0; rd_row = '0; rd_col = '0;
        @(negedge clk);
        @(negedge clk);
        mr = 1'b0;
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b required 0", rdy); end
        checks++;
        if (rd_char !== 6'h00) begin errors++; $display("FAIL reset_rd_char: got %h required 00", rd_char); end
        checks++;
        if (rd_curs !== 1'b0) begin errors++; $display("FAIL reset_rd_curs: got %b required 0", rd_curs); end
        checks++;
        if (curs_row !== 0 || curs_col !== 0 || top_row !== 0) begin
            errors++;
            $display("FAIL reset_cursor: got row %0d col %0d top %0d required 0 0 0", curs_row, curs_col, top_row);
        end
        checks++;
        wait_rdy(n);
        if (n != 960) begin errors++; $display("FAIL reset_clear_len: got %0d cycles required 960", n); end
        checks++;
        bad = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c);
                if (rdata !== 6'h00) bad++;
            end
        end
        if (bad != 0) begin errors++; $display("FAIL reset_blank: got %0d nonblank cells required 0", bad); end
        checks++;
    endtask

    task automatic test_print;
        send_char(7'h41);
        send_char(7'h42);
        read_cell(0, 0);
        if (rdata !== 6'h21 || rcurs !== 1'b0) begin
            errors++; $display("FAIL print_a: got %h curs %b required 21 curs 0", rdata, rcurs);
        end
        checks++;
        read_cell(0, 1);
        if (rdata !== 6'h22 || rcurs !== 1'b0) begin
            errors++; $display("FAIL print_b: got %h curs %b required 22 curs 0", rdata, rcurs);
        end
        checks++;
        read_cell(0, 2);
        if (rcurs !== 1'b1) begin errors++; $display("FAIL print_curs_hit: got %b required 1", rcurs); end
        checks++;
        read_cell(0, 3);
        if (rcurs !== 1'b0) begin errors++; $display("FAIL print_curs_miss: got %b required 0", rcurs); end
        checks++;
        if (curs_row !== 0 || curs_col !== 2) begin
            errors++; $display("FAIL print_cursor: got (%0d,%0d) required (0,2)", curs_row, curs_col);
        end
        checks++;
    endtask

    task automatic test_wrap;
        int bad;
        send_char(7'h0D);
        if (curs_row !== 1 || curs_col !== 0) begin
            errors++; $display("FAIL cr_cursor: got (%0d,%0d) required (1,0)", curs_row, curs_col);
        end
        checks++;
        for (int i = 0; i < COLS; i++) send_char(7'(7'h41 + i % 26));
        if (curs_row !== 2 || curs_col !== 0) begin
            errors++; $display("FAIL wrap_cursor: got (%0d,%0d) required (2,0)", curs_row, curs_col);
        end
        checks++;
        send_char(7'h5A);
        read_cell(2, 0);
        if (rdata !== 6'h3A) begin errors++; $display("FAIL wrap_41st: got %h required 3a", rdata); end
        checks++;
        bad = 0;
        for (int c = 0; c < COLS; c++) begin
            read_cell(1, c);
            if (rdata !== code_of(7'(7'h41 + c % 26))) bad++;
        end
        if (bad != 0) begin errors++; $display("FAIL wrap_row1: got %0d wrong cells required 0", bad); end
        checks++;
    endtask

    task automatic test_scroll;
        int n;
        int bad;
        for (int i = 0; i < 21; i++) send_char(7'h0D);
        if (curs_row !== 23 || top_row !== 0) begin
            errors++; $display("FAIL scroll_pre: got row %0d top %0d required 23 0", curs_row, top_row);
        end
        checks++;
        send_char(7'h51);
        send_char(7'h0D);
        wait_rdy(n);
        if (n != 40) begin errors++; $display("FAIL scroll_len: got %0d cycles required 40", n); end
        checks++;
        if (top_row !== 1 || curs_row !== 23 || curs_col !== 0) begin
            errors++;
            $display("FAIL scroll_state: got top %0d (%0d,%0d) required top 1 (23,0)", top_row, curs_row, curs_col);
        end
        checks++;
        bad = 0;
        for (int c = 0; c < COLS; c++) begin
            read_cell(23, c);
            if (rdata !== 6'h00) bad++;
        end
        if (bad != 0) begin errors++; $display("FAIL scroll_bottom_blank: got %0d nonblank required 0", bad); end
        checks++;
        bad = 0;
        for (int c = 0; c < COLS; c++) begin
            read_cell(0, c);
            if (rdata !== code_of(7'(7'h41 + c % 26))) bad++;
        end
        if (bad != 0) begin errors++; $display("FAIL scroll_shift: got %0d wrong cells required 0", bad); end
        checks++;
        read_cell(22, 0);
        if (rdata !== 6'h31) begin errors++; $display("FAIL scroll_row22: got %h required 31", rdata); end
        checks++;
    endtask

    task automatic test_clear_mid_scroll;
        int n;
        send_char(7'h0D);
        repeat (5) @(negedge clk);
        if (rdy !== 1'b0) begin errors++; $display("FAIL midscroll_rdy: got %b required 0", rdy); end
        checks++;
        rd = 7'h58;
        da = 1'b1;
        clr_btn = 1'b1;
        @(negedge clk);
        clr_btn = 1'b0;
        wait_rdy(n);
        if (n != 960) begin errors++; $display("FAIL midscroll_clear_len: got %0d cycles required 960", n); end
        checks++;
        if (curs_row !== 0 || curs_col !== 0 || top_row !== 0) begin
            errors++;
            $display("FAIL midscroll_held: got (%0d,%0d) top %0d required (0,0) top 0", curs_row, curs_col, top_row);
        end
        checks++;
        @(negedge clk);
        da = 1'b0;
        if (curs_col !== 1) begin errors++; $display("FAIL midscroll_consume: got col %0d required 1", curs_col); end
        checks++;
        read_cell(0, 0);
        if (rdata !== 6'h38) begin errors++; $display("FAIL midscroll_char: got %h required 38", rdata); end
        checks++;
        read_cell(22, 0);
        if (rdata !== 6'h00) begin errors++; $display("FAIL midscroll_cleared: got %h required 00", rdata); end
        checks++;
    endtask

    task automatic test_ctrl_ignored;
        send_char(7'h07);
        send_char(7'h1B);
        if (curs_row !== 0 || curs_col !== 1) begin
            errors++; $display("FAIL ctrl_cursor: got (%0d,%0d) required (0,1)", curs_row, curs_col);
        end
        checks++;
        read_cell(0, 1);
        if (rdata !== 6'h00) begin errors++; $display("FAIL ctrl_mem: got %h required 00", rdata); end
        checks++;
    endtask

    task automatic test_backspace;
        send_char(7'h0D);
        send_char(7'h41);
        send_char(7'h42);
        send_char(7'h08);
`ifdef TERM_BACKSPACE_EN
        if (curs_col !== 1) begin errors++; $display("FAIL bs_col: got %0d required 1", curs_col); end
        checks++;
        read_cell(1, 1);
        if (rdata !== 6'h00) begin errors++; $display("FAIL bs_erase: got %h required 00", rdata); end
        checks++;
        read_cell(1, 0);
        if (rdata !== 6'h21) begin errors++; $display("FAIL bs_keep: got %h required 21", rdata); end
        checks++;
        send_char(7'h08);
        send_char(7'h08);
        if (curs_row !== 1 || curs_col !== 0) begin
            errors++; $display("FAIL bs_col0: got (%0d,%0d) required (1,0)", curs_row, curs_col);
        end
        checks++;
`else
        if (curs_col !== 2) begin errors++; $display("FAIL bs_ignored_col: got %0d required 2", curs_col); end
        checks++;
        read_cell(1, 1);
        if (rdata !== 6'h22) begin errors++; $display("FAIL bs_ignored_mem: got %h required 22", rdata); end
        checks++;
`endif
    endtask

    initial begin
        test_reset;
        test_print;
        test_wrap;
        test_scroll;
        test_clear_mid_scroll;
        test_ctrl_ignored;
        test_backspace;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/term_screen_ctrl.md
Name: term_screen_ctrl

Overview:
- Parametrised character-terminal core and successor to the shift-register Apple-1 display path.
- Holds a COLS x ROWS RAM screen buffer and accepts 7-bit ASCII through a da/rdy handshake.
- Places printable characters at the cursor and handles CR, line wrap, hardware scroll (rotating top-row pointer) and full-screen clear.
- The raster/timing front end reads the buffer through a separate 1-cycle-latency read port.

Parameters:
- COLS, 40: characters per row; range 2..128.
- ROWS, 24: rows on screen; range 2..64.
- COL_W, $clog2(COLS): column index width.
- ROW_W, $clog2(ROWS): row index width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- mr  in  1  master reset; synchronous, active-high.
- rd  in  7 [7:1]  ASCII input; rd[n] = ASCII bit n-1.
- da  in  1  data available; char accepted on an edge where da=1 and rdy=1.
- rdy  out  1  ready for a character.
- clr_btn  in  1  clear request, level-sampled.
- rd_row  in  ROW_W  display read row; logical, 0 = top line.
- rd_col  in  COL_W  display read column.
- rd_char  out  6  stored code at (rd_row, rd_col); 1-cycle latency.
- rd_curs  out  1  high when (rd_row, rd_col) equals the cursor position; 1-cycle latency.
- curs_row  out  ROW_W  cursor logical row.
- curs_col  out  COL_W  cursor column.
- top_row  out  ROW_W  physical row currently shown as logical row 0.

Behaviour:
- Stored code = {rd[7], rd[5:1]}. Blank (space) = 6'h00.
- Control character: rd[7]=0 and rd[6]=0. CR = 7'h0D.
- Physical row = (logical row + top_row) mod ROWS. RAM address = phys_row*COLS + col.
- States:
  - CLEAR: writes 6'h00 to one cell per cycle, 0..ROWS*COLS-1.
  - IDLE: rdy=1.
  - SCROLL: writes 6'h00 to one cell per cycle across the new bottom row, COLS cycles.
- Reset (mr=1): enters CLEAR with clr_ptr=0, cursor=(0,0), top_row=0, rdy=0, rd_char=0, rd_curs=0. Reset mid-scroll or mid-clear aborts and restarts the full clear.
- Priority: mr > clr_btn > da.
- clr_btn=1 in any state: (re)enters CLEAR at clr_ptr=0 and resets cursor and top_row. Holding clr_btn keeps restarting the clear.
- CLEAR ends after the cycle that writes the last cell; next state IDLE.
- IDLE, accepted printable character:
  - Write the code at the cursor.
  - If curs_col < COLS-1: curs_col+1.
  - Otherwise perform a newline.
- IDLE, accepted CR: newline. Other control characters are accepted, with no effect.
- Newline:
  - If curs_row < ROWS-1: curs_row+1, curs_col=0, stay in IDLE.
  - Otherwise: top_row = (top_row+1) mod ROWS, curs_col=0, curs_row stays ROWS-1, go to SCROLL.
  - On the SCROLL entry edge, rdy falls.
- SCROLL: clears the physical row that becomes logical ROWS-1, then returns to IDLE. rdy=0 throughout; back-to-back scrolls are therefore impossible.
- rdy is combinational from state: 1 only in IDLE, 0 during any pending scroll or clear. A character presented while rdy=0 is not consumed, and the source holds it.
- Display read port is independent of writes: registered RAM read, rd_char valid 1 cycle after the address.
- Read/write collision on the same cell returns the old data (read-first).
- rd_curs is registered in the same cycle as rd_char, using the cursor value current at sample time. It is forced to 0 outside IDLE.
- top_row wraps from ROWS-1 to 0. Cursor never exceeds (ROWS-1, COLS-1).

Optional Feature:
- Macro: TERM_BACKSPACE_EN.
- Defined: accepted 7'h08 (BS) in IDLE with curs_col > 0 sets curs_col-1 and writes 6'h00 at the new position. BS at col 0 has no effect; no reverse line wrap.
- Undefined: BS is an ordinary ignored control character, as in the Apple-1.

Decomposition:
- Package term_pkg holds:
  - state enum {CLEAR, IDLE, SCROLL};
  - constants BLANK_CODE=6'h00, ASCII_CR=7'h0D, ASCII_BS=7'h08;
  - function to_code(rd) returning {rd[7], rd[5:1]};
  - function is_ctrl(rd).
- One sub-module, term_ram: simple dual-port RAM, one write port and one registered read-first read port, parametrised DEPTH and WIDTH=6.

Test Plan (COLS=40, ROWS=24):
- Pulse mr 1 cycle -> rdy low exactly 960 cycles, then high. Every rd_char read = 6'h00; curs=(0,0); top_row=0.
- Send 'A' (7'h41) then 'B' (7'h42) -> read (0,0)=6'h21 and (0,1)=6'h22 after 1 cycle; curs_col=2; rd_curs=1 at (0,2) only.
- Send 40 printable chars from col 0 -> wrap to curs=(1,0); 41st char lands at (1,0).
- Fill to row 23 and send CR -> top_row=1, rdy low 40 cycles, logical row 23 reads all 6'h00, old logical row 1 now reads at logical row 0.
- Assert clr_btn mid-SCROLL, and hold da=1 with a char throughout -> full 960-cycle clear restarts, the char is not consumed until rdy=1, then written at (0,0).
- TERM_BACKSPACE_EN: send 'A', 'B', BS -> curs_col=1, (0,1)=6'h00, (0,0)=6'h21. BS at col 0 -> no change. Without the macro: BS leaves curs_col=2 and memory unchanged.
